// File: rtl/rob_multi_pkg.sv
// rtl/rob_multi_pkg.sv - shared widths, defaults and entry types of the reorder buffer
package rob_multi_pkg;

    localparam int ROB_DEPTH    = 16;
    localparam int ROB_DISP_W   = 2;
    localparam int ROB_CDB_N    = 2;
    localparam int ROB_COMMIT_W = 2;
    localparam int ROB_DATA_W   = 32;
    localparam int ROB_AREG_W   = 5;
    localparam logic [ROB_DATA_W-1:0] ROB_EXC_VEC = 32'h80;

    typedef struct packed {
        logic                  busy;
        logic                  done;
        logic                  exc;
        logic                  mis;
        logic                  has_dest;
        logic [ROB_AREG_W-1:0] dest;
        logic [ROB_DATA_W-1:0] value;
        logic [ROB_DATA_W-1:0] target;
    } rob_entry_t;

    // Subset of an entry the retire scan needs; keeps the scanner free of result data.
    typedef struct packed {
        logic                  busy;
        logic                  done;
        logic                  exc;
        logic                  mis;
        logic [ROB_DATA_W-1:0] target;
    } rob_scan_t;

endpackage

// File: rtl/rob_multi_if.sv
// rtl/rob_multi_if.sv - dispatch, completion, commit and status bundle of the reorder buffer
interface rob_multi_if
    import rob_multi_pkg::*;
#(
    parameter int DISP_W   = ROB_DISP_W,
    parameter int CDB_N    = ROB_CDB_N,
    parameter int COMMIT_W = ROB_COMMIT_W,
    parameter int TAG_W    = $clog2(ROB_DEPTH),
    parameter int DATA_W   = ROB_DATA_W,
    parameter int AREG_W   = ROB_AREG_W
);
    logic [DISP_W-1:0]          disp_valid;
    logic [DISP_W-1:0]          disp_has_dest;
    logic [DISP_W*AREG_W-1:0]   disp_dest;
    logic                       disp_ready;
    logic [DISP_W*TAG_W-1:0]    disp_tag;

    logic [CDB_N-1:0]           cdb_valid;
    logic [CDB_N*TAG_W-1:0]     cdb_tag;
    logic [CDB_N*DATA_W-1:0]    cdb_value;
    logic [CDB_N-1:0]           cdb_exc;
    logic [CDB_N-1:0]           cdb_mispred;
    logic [CDB_N*DATA_W-1:0]    cdb_target;

    logic [COMMIT_W-1:0]        commit_valid;
    logic [COMMIT_W-1:0]        commit_has_dest;
    logic [COMMIT_W*AREG_W-1:0] commit_dest;
    logic [COMMIT_W*DATA_W-1:0] commit_value;

    logic                       flush;
    logic [DATA_W-1:0]          flush_pc;
    logic                       flush_exc;
    logic [TAG_W:0]             count;
    logic                       empty;
    logic                       full;

    modport master (
        output disp_valid, disp_has_dest, disp_dest,
        output cdb_valid, cdb_tag, cdb_value, cdb_exc, cdb_mispred, cdb_target,
        input  disp_ready, disp_tag,
        input  commit_valid, commit_has_dest, commit_dest, commit_value,
        input  flush, flush_pc, flush_exc, count, empty, full
    );

    modport slave (
        input  disp_valid, disp_has_dest, disp_dest,
        input  cdb_valid, cdb_tag, cdb_value, cdb_exc, cdb_mispred, cdb_target,
        output disp_ready, disp_tag,
        output commit_valid, commit_has_dest, commit_dest, commit_value,
        output flush, flush_pc, flush_exc, count, empty, full
    );

endinterface

// File: rtl/rob_multi_commit_sel.sv
// rtl/rob_multi_commit_sel.sv - combinational in-order retire scan over the head window
module rob_multi_commit_sel
    import rob_multi_pkg::*;
#(
    parameter int                     COMMIT_W = ROB_COMMIT_W,
    parameter logic [ROB_DATA_W-1:0]  EXC_VEC  = ROB_EXC_VEC
) (
    input  rob_scan_t [COMMIT_W-1:0] win,
    output logic [COMMIT_W-1:0]      retire,
    output logic                     flush_req,
    output logic                     flush_exc,
    output logic [ROB_DATA_W-1:0]    flush_pc
);
    logic stop;

    // A faulting entry never retires; a mispredicted branch retires and then ends the group.
    always_comb begin
        retire    = '0;
        flush_req = 1'b0;
        flush_exc = 1'b0;
        flush_pc  = '0;
        stop      = 1'b0;
        for (int k = 0; k < COMMIT_W; k++) begin
            if (!stop) begin
                if (!(win[k].busy && win[k].done)) begin
                    stop = 1'b1;
                end else if (win[k].exc) begin
                    stop      = 1'b1;
                    flush_req = 1'b1;
                    flush_exc = 1'b1;
                    flush_pc  = EXC_VEC;
                end else begin
                    retire[k] = 1'b1;
                    if (win[k].mis) begin
                        stop      = 1'b1;
                        flush_req = 1'b1;
                        flush_pc  = win[k].target;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/rob_multi.sv
// rtl/rob_multi.sv - multi-lane reorder buffer: dispatch allocate, CDB complete, in-order commit, precise flush
module rob_multi
    import rob_multi_pkg::*;
#(
    parameter int                    DEPTH    = ROB_DEPTH,
    parameter int                    DISP_W   = ROB_DISP_W,
    parameter int                    CDB_N    = ROB_CDB_N,
    parameter int                    COMMIT_W = ROB_COMMIT_W,
    parameter logic [ROB_DATA_W-1:0] EXC_VEC  = ROB_EXC_VEC
) (
    input  logic       clk,
    input  logic       rst_n,
    rob_multi_if.slave bus
);
    localparam int DATA_W = ROB_DATA_W;
    localparam int AREG_W = ROB_AREG_W;
    localparam int TAG_W  = $clog2(DEPTH);
    localparam int PTR_W  = TAG_W + 1;

    rob_entry_t                 rob_q [DEPTH];
    logic [PTR_W-1:0]           head_q;
    logic [PTR_W-1:0]           tail_q;
    logic [PTR_W-1:0]           occ;
    logic [PTR_W-1:0]           disp_n;
    logic [PTR_W-1:0]           ret_n;
    logic [TAG_W-1:0]           head_idx;
    logic [TAG_W-1:0]           tail_idx;
    logic [TAG_W-1:0]           win_idx   [COMMIT_W];
    logic [TAG_W-1:0]           alloc_idx [DISP_W];
    logic [TAG_W-1:0]           cdb_idx   [CDB_N];
    rob_scan_t [COMMIT_W-1:0]   scan_win;
    logic [COMMIT_W-1:0]        retire;
    logic                       sel_flush;
    logic                       sel_exc;
    logic [DATA_W-1:0]          sel_pc;
    logic                       disp_ok;
    logic                       dup_tag;

    logic [COMMIT_W-1:0]        commit_valid_q;
    logic [COMMIT_W-1:0]        commit_has_dest_q;
    logic [COMMIT_W*AREG_W-1:0] commit_dest_q;
    logic [COMMIT_W*DATA_W-1:0] commit_value_q;
    logic                       flush_q;
    logic                       flush_exc_q;
    logic [DATA_W-1:0]          flush_pc_q;

    assign head_idx = head_q[TAG_W-1:0];
    assign tail_idx = tail_q[TAG_W-1:0];
    assign occ      = tail_q - head_q;

    // Space is judged on pre-edge occupancy; same-cycle commits do not help dispatch.
    assign disp_ok  = ((PTR_W'(DEPTH) - occ) >= PTR_W'(DISP_W)) && !sel_flush;

    always_comb begin
        disp_n       = '0;
        bus.disp_tag = '0;
        for (int i = 0; i < DISP_W; i++) begin
            alloc_idx[i] = tail_idx + TAG_W'(i);
            bus.disp_tag[i*TAG_W +: TAG_W] = alloc_idx[i];
            if (bus.disp_valid[i]) disp_n = disp_n + PTR_W'(1);
        end
    end

    always_comb begin
        for (int k = 0; k < COMMIT_W; k++) begin
            win_idx[k]         = head_idx + TAG_W'(k);
            scan_win[k].busy   = rob_q[win_idx[k]].busy;
            scan_win[k].done   = rob_q[win_idx[k]].done;
            scan_win[k].exc    = rob_q[win_idx[k]].exc;
            scan_win[k].mis    = rob_q[win_idx[k]].mis;
            scan_win[k].target = rob_q[win_idx[k]].target;
        end
    end

    always_comb begin
        ret_n = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            if (retire[k]) ret_n = ret_n + PTR_W'(1);
        end
    end

    always_comb begin
        dup_tag = 1'b0;
        for (int c = 0; c < CDB_N; c++) begin
            cdb_idx[c] = bus.cdb_tag[c*TAG_W +: TAG_W];
        end
        for (int i = 0; i < CDB_N; i++) begin
            for (int j = i + 1; j < CDB_N; j++) begin
                if (bus.cdb_valid[i] && bus.cdb_valid[j] && (cdb_idx[i] == cdb_idx[j])) dup_tag = 1'b1;
            end
        end
    end

    rob_multi_commit_sel #(
        .COMMIT_W (COMMIT_W),
        .EXC_VEC  (EXC_VEC)
    ) u_commit_sel (
        .win       (scan_win),
        .retire    (retire),
        .flush_req (sel_flush),
        .flush_exc (sel_exc),
        .flush_pc  (sel_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q            <= '0;
            tail_q            <= '0;
            commit_valid_q    <= '0;
            commit_has_dest_q <= '0;
            commit_dest_q     <= '0;
            commit_value_q    <= '0;
            flush_q           <= 1'b0;
            flush_exc_q       <= 1'b0;
            flush_pc_q        <= '0;
            for (int e = 0; e < DEPTH; e++) rob_q[e] <= '0;
        end else begin
            head_q         <= head_q + ret_n;
            commit_valid_q <= retire;
            for (int k = 0; k < COMMIT_W; k++) begin
                commit_has_dest_q[k]                <= rob_q[win_idx[k]].has_dest;
                commit_dest_q[k*AREG_W +: AREG_W]   <= rob_q[win_idx[k]].dest;
                commit_value_q[k*DATA_W +: DATA_W]  <= rob_q[win_idx[k]].value;
            end
            flush_q     <= sel_flush;
            flush_exc_q <= sel_exc;
            flush_pc_q  <= sel_pc;

            if (sel_flush) begin
                tail_q <= head_q + ret_n;
                for (int e = 0; e < DEPTH; e++) rob_q[e].busy <= 1'b0;
            end else begin
                // Later channels overwrite earlier ones on a duplicate tag.
                for (int c = 0; c < CDB_N; c++) begin
                    if (bus.cdb_valid[c] && rob_q[cdb_idx[c]].busy) begin
                        rob_q[cdb_idx[c]].done   <= 1'b1;
                        rob_q[cdb_idx[c]].value  <= bus.cdb_value[c*DATA_W +: DATA_W];
                        rob_q[cdb_idx[c]].exc    <= bus.cdb_exc[c];
                        rob_q[cdb_idx[c]].mis    <= bus.cdb_mispred[c];
                        rob_q[cdb_idx[c]].target <= bus.cdb_target[c*DATA_W +: DATA_W];
                    end
                end
                for (int k = 0; k < COMMIT_W; k++) begin
                    if (retire[k]) rob_q[win_idx[k]].busy <= 1'b0;
                end
                if (disp_ok) begin
                    tail_q <= tail_q + disp_n;
                    for (int i = 0; i < DISP_W; i++) begin
                        if (bus.disp_valid[i]) begin
                            rob_q[alloc_idx[i]].busy     <= 1'b1;
                            rob_q[alloc_idx[i]].done     <= 1'b0;
                            rob_q[alloc_idx[i]].exc      <= 1'b0;
                            rob_q[alloc_idx[i]].mis      <= 1'b0;
                            rob_q[alloc_idx[i]].has_dest <= bus.disp_has_dest[i];
                            rob_q[alloc_idx[i]].dest     <= bus.disp_dest[i*AREG_W +: AREG_W];
                        end
                    end
                end
            end
        end
    end

    assign bus.disp_ready      = disp_ok;
    assign bus.commit_valid    = commit_valid_q;
    assign bus.commit_has_dest = commit_has_dest_q;
    assign bus.commit_dest     = commit_dest_q;
    assign bus.commit_value    = commit_value_q;
    assign bus.flush           = flush_q;
    assign bus.flush_exc       = flush_exc_q;
    assign bus.flush_pc        = flush_pc_q;
    assign bus.count           = occ;
    assign bus.empty           = (occ == '0);
    assign bus.full            = (occ == PTR_W'(DEPTH));

    no_dup_cdb_tag: assert property (@(posedge clk) disable iff (!rst_n) !dup_tag);

endmodule

// File: tb/tb_rob_multi.sv
// tb/tb_rob_multi.sv - directed and randomized checks of rob_multi against a queue-based reference model
module tb_rob_multi;
    import rob_multi_pkg::*;

    localparam int DEPTH = 16;
    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rob_multi_if bus ();
    rob_multi dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int       abs_idx;
        bit       has_dest;
        bit [4:0] dest;
        bit       done;
        bit       exc;
        bit       mis;
        bit [31:0] value;
        bit [31:0] target;
    } m_ent_t;

    m_ent_t mq[$];
    int     m_tail = 0;

    bit        dv [2];
    bit        dh [2];
    bit [4:0]  dd [2];
    bit        cv [2];
    bit [3:0]  ct [2];
    bit [31:0] cval [2];
    bit [31:0] ctgt [2];
    bit        cexc [2];
    bit        cmis [2];

    task automatic idle();
        for (int i = 0; i < 2; i++) begin
            dv[i] = 0; dh[i] = 0; dd[i] = '0;
            cv[i] = 0; ct[i] = '0; cval[i] = '0; ctgt[i] = '0; cexc[i] = 0; cmis[i] = 0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            bus.disp_valid[i]           = dv[i];
            bus.disp_has_dest[i]        = dh[i];
            bus.disp_dest[i*5 +: 5]     = dd[i];
            bus.cdb_valid[i]            = cv[i];
            bus.cdb_tag[i*TAG_W +: TAG_W] = ct[i];
            bus.cdb_value[i*32 +: 32]   = cval[i];
            bus.cdb_exc[i]              = cexc[i];
            bus.cdb_mispred[i]          = cmis[i];
            bus.cdb_target[i*32 +: 32]  = ctgt[i];
        end
    endtask

    task automatic set_disp(input int n, input bit [4:0] d0, input bit [4:0] d1);
        dv[0] = (n > 0); dv[1] = (n > 1);
        dh[0] = 1; dh[1] = 1;
        dd[0] = d0; dd[1] = d1;
    endtask

    task automatic set_cdb(input int c, input bit [3:0] tag, input bit [31:0] val,
                           input bit exc, input bit mis, input bit [31:0] tgt);
        cv[c] = 1; ct[c] = tag; cval[c] = val; cexc[c] = exc; cmis[c] = mis; ctgt[c] = tgt;
    endtask

    // One clock: comb outputs checked at negedge, model advanced, registered outputs checked after posedge.
    task automatic step();
        int        nret;
        int        head;
        bit        fl, fl_exc, ready;
        bit [31:0] fl_pc;
        bit        exp_hd  [2];
        bit [4:0]  exp_dst [2];
        bit [31:0] exp_val [2];
        m_ent_t    e;

        drive();
        @(negedge clk);
        nret = 0; fl = 0; fl_exc = 0; fl_pc = '0;
        for (int k = 0; k < 2 && k < mq.size(); k++) begin
            if (!mq[k].done) break;
            if (mq[k].exc) begin
                fl = 1; fl_exc = 1; fl_pc = 32'h80;
                break;
            end
            exp_hd[nret] = mq[k].has_dest; exp_dst[nret] = mq[k].dest; exp_val[nret] = mq[k].value;
            nret++;
            if (mq[k].mis) begin
                fl = 1; fl_pc = mq[k].target;
                break;
            end
        end
        ready = ((DEPTH - mq.size()) >= 2) && !fl;
        check_eq("disp_ready", 64'(bus.disp_ready), 64'(ready));
        for (int i = 0; i < 2; i++)
            check_eq("disp_tag", 64'(bus.disp_tag[i*TAG_W +: TAG_W]), 64'((m_tail + i) % DEPTH));
        check_eq("count", 64'(bus.count), 64'(mq.size()));
        check_eq("empty", 64'(bus.empty), 64'(mq.size() == 0));
        check_eq("full", 64'(bus.full), 64'(mq.size() == DEPTH));

        head = m_tail - mq.size();
        if (fl) begin
            mq.delete();
            m_tail = head + nret;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (cv[c]) begin
                    for (int j = 0; j < mq.size(); j++) begin
                        if (mq[j].abs_idx % DEPTH == int'(ct[c])) begin
                            mq[j].done = 1; mq[j].value = cval[c]; mq[j].exc = cexc[c];
                            mq[j].mis = cmis[c]; mq[j].target = ctgt[c];
                        end
                    end
                end
            end
            repeat (nret) void'(mq.pop_front());
            if (ready) begin
                for (int i = 0; i < 2; i++) begin
                    if (dv[i]) begin
                        e = '{abs_idx: m_tail, has_dest: dh[i], dest: dd[i], done: 0, exc: 0, mis: 0,
                              value: '0, target: '0};
                        mq.push_back(e);
                        m_tail++;
                    end
                end
            end
        end

        @(posedge clk);
        #1;
        check_eq("commit_valid", 64'(bus.commit_valid), 64'((1 << nret) - 1));
        for (int k = 0; k < nret; k++) begin
            check_eq("commit_has_dest", 64'(bus.commit_has_dest[k]), 64'(exp_hd[k]));
            check_eq("commit_dest", 64'(bus.commit_dest[k*5 +: 5]), 64'(exp_dst[k]));
            check_eq("commit_value", 64'(bus.commit_value[k*32 +: 32]), 64'(exp_val[k]));
        end
        check_eq("flush", 64'(bus.flush), 64'(fl));
        if (fl) begin
            check_eq("flush_pc", 64'(bus.flush_pc), 64'(fl_pc));
            check_eq("flush_exc", 64'(bus.flush_exc), 64'(fl_exc));
        end
    endtask

    task automatic do_reset();
        idle();
        drive();
        rst_n = 1'b0;
        #1;
        check_eq("rst_count", 64'(bus.count), 64'd0);
        check_eq("rst_empty", 64'(bus.empty), 64'd1);
        check_eq("rst_full", 64'(bus.full), 64'd0);
        check_eq("rst_commit_valid", 64'(bus.commit_valid), 64'd0);
        check_eq("rst_flush", 64'(bus.flush), 64'd0);
        check_eq("rst_flush_pc", 64'(bus.flush_pc), 64'd0);
        check_eq("rst_flush_exc", 64'(bus.flush_exc), 64'd0);
        mq.delete();
        m_tail = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        int n, r, j;
        idle();
        n = $urandom_range(0, 2);
        for (int i = 0; i < 2; i++) begin
            dv[i] = (i < n);
            dh[i] = 1'($urandom_range(0, 1));
            dd[i] = 5'($urandom);
        end
        for (int c = 0; c < 2; c++) begin
            r = $urandom_range(0, 99);
            if (r < 55 && mq.size() > 0) begin
                j = $urandom_range(0, mq.size() - 1);
                if (!mq[j].done) begin
                    cv[c] = 1; ct[c] = 4'(mq[j].abs_idx % DEPTH);
                end
            end else if (r < 62) begin
                cv[c] = 1; ct[c] = 4'($urandom);
            end
            cval[c] = $urandom;
            ctgt[c] = $urandom;
            cexc[c] = ($urandom_range(0, 39) == 0);
            cmis[c] = ($urandom_range(0, 19) == 0);
        end
        if (cv[0] && cv[1] && ct[0] == ct[1]) cv[1] = 0;
    endtask

    initial begin
        idle();
        drive();
        do_reset();

        // Fill: tags 0..15, dest = tag+1
        for (int i = 0; i < 8; i++) begin
            idle(); set_disp(2, 5'(2*i + 1), 5'(2*i + 2)); step();
        end
        check_eq("t1_full", 64'(bus.full), 64'd1);
        check_eq("t1_ready", 64'(bus.disp_ready), 64'd0);
        check_eq("t1_count", 64'(bus.count), 64'd16);

        // Out-of-order completion of tags 1, 0
        idle(); set_cdb(0, 4'd1, 32'h1111, 0, 0, 0); step();
        idle(); set_cdb(0, 4'd0, 32'h1000, 0, 0, 0); step();
        check_eq("t2_no_bypass", 64'(bus.commit_valid), 64'd0);
        idle(); step();
        check_eq("t2_cv", 64'(bus.commit_valid), 64'b11);
        check_eq("t2_dest0", 64'(bus.commit_dest[4:0]), 64'd1);
        check_eq("t2_dest1", 64'(bus.commit_dest[9:5]), 64'd2);
        check_eq("t2_val0", 64'(bus.commit_value[31:0]), 64'h1000);
        check_eq("t2_val1", 64'(bus.commit_value[63:32]), 64'h1111);
        check_eq("t2_count", 64'(bus.count), 64'd14);

        // Tag 3 waits behind pending tag 2
        idle(); set_cdb(1, 4'd3, 32'h3333, 0, 0, 0); step();
        idle(); step();
        check_eq("t3_blocked", 64'(bus.commit_valid), 64'd0);
        idle(); set_cdb(0, 4'd2, 32'h2222, 0, 0, 0); step();
        idle(); step();
        check_eq("t3_cv", 64'(bus.commit_valid), 64'b11);
        check_eq("t3_count", 64'(bus.count), 64'd12);

        // Exception on tag 5
        idle(); set_cdb(0, 4'd4, 32'h4444, 0, 0, 0); set_cdb(1, 4'd5, 32'h5555, 1, 0, 0); step();
        idle(); step();
        check_eq("t4_cv", 64'(bus.commit_valid), 64'b01);
        check_eq("t4_flush", 64'(bus.flush), 64'd1);
        check_eq("t4_exc", 64'(bus.flush_exc), 64'd1);
        check_eq("t4_pc", 64'(bus.flush_pc), 64'h80);
        check_eq("t4_empty", 64'(bus.empty), 64'd1);
        idle(); set_cdb(0, 4'd7, 32'h7777, 0, 0, 0); step();
        check_eq("t4_pulse", 64'(bus.flush), 64'd0);
        idle(); step();
        check_eq("t4_late_cdb", 64'(bus.commit_valid), 64'd0);

        // Mispredict on tag 2
        do_reset();
        idle(); set_disp(2, 5'd10, 5'd11); step();
        idle(); set_disp(2, 5'd12, 5'd13); step();
        idle(); set_cdb(0, 4'd0, 32'hA0, 0, 0, 0); set_cdb(1, 4'd1, 32'hA1, 0, 0, 0); step();
        idle(); set_cdb(0, 4'd2, 32'hA2, 0, 1, 32'h400); step();
        check_eq("t5_cv01", 64'(bus.commit_valid), 64'b11);
        idle(); step();
        check_eq("t5_cv", 64'(bus.commit_valid), 64'b01);
        check_eq("t5_flush", 64'(bus.flush), 64'd1);
        check_eq("t5_exc", 64'(bus.flush_exc), 64'd0);
        check_eq("t5_pc", 64'(bus.flush_pc), 64'h400);
        check_eq("t5_count", 64'(bus.count), 64'd0);
        check_eq("t5_tail", 64'(bus.disp_tag[3:0]), 64'd3);

        // Walk the head to 15, then dispatch and commit across the wrap
        for (int r = 0; r < 6; r++) begin
            idle(); set_disp(2, 5'(r), 5'(r + 1)); step();
            idle();
            set_cdb(0, 4'(3 + 2*r), 32'(r), 0, 0, 0);
            set_cdb(1, 4'(4 + 2*r), 32'(r + 100), 0, 0, 0);
            step();
            idle(); step();
        end
        check_eq("t6_tag0", 64'(bus.disp_tag[3:0]), 64'd15);
        check_eq("t6_tag1", 64'(bus.disp_tag[7:4]), 64'd0);
        idle(); set_disp(2, 5'd20, 5'd21); step();
        idle(); set_cdb(0, 4'd15, 32'hF15, 0, 0, 0); set_cdb(1, 4'd0, 32'hF00, 0, 0, 0); step();
        idle(); step();
        check_eq("t6_cv", 64'(bus.commit_valid), 64'b11);
        check_eq("t6_val1", 64'(bus.commit_value[63:32]), 64'hF00);
        check_eq("t6_count", 64'(bus.count), 64'd0);
        check_eq("t6_head", 64'(bus.disp_tag[3:0]), 64'd1);

        // Reset with completed work pending: nothing may retire
        idle(); set_disp(2, 5'd1, 5'd2); step();
        idle(); set_cdb(0, 4'd1, 32'h1, 0, 0, 0); set_cdb(1, 4'd2, 32'h2, 0, 0, 0); step();
        do_reset();

        for (int n = 0; n < 3000; n++) begin
            rand_inputs();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
